// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap sequencer: CSR addresses, cause codes,
// FSM encoding and the latched-cause record.
package trap_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam logic [31:0] ZERO = 32'h0000_0000;
  localparam logic STOP = 1'b1;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam logic [3:0] CAUSE_MEI     = 4'd11;
  localparam logic [3:0] CAUSE_MSI     = 4'd3;
  localparam logic [3:0] CAUSE_MTI     = 4'd7;
  localparam logic [3:0] CAUSE_ECALL_M = 4'd11;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_TRAP = 3'd2,
    ST_MRET = 3'd3,
    ST_HOLD = 3'd4
  } state_t;

  typedef struct packed {
    logic       irq;
    logic [3:0] code;
  } cause_t;

  function automatic logic [31:0] cause_word(cause_t c);
    return {c.irq, 27'b0, c.code};
  endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Pipeline-facing bundle of the trap sequencer: interrupt lines, EXE events,
// CSR access and the redirect request towards pipe_ctrl.
interface trap_ctrl_if
  import trap_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = 32
);
  logic                  irq_ext_in;
  logic                  irq_sw_in;
  logic                  irq_timer_in;
  logic                  ecall_in;
  logic                  mret_in;
  logic [5:0]            stall_in;
  logic                  exe_jump_enable_in;
  logic [ADDR_WIDTH-1:0] epc_in;
  logic                  csr_we_in;
  logic [11:0]           csr_waddr_in;
  logic [DATA_WIDTH-1:0] csr_wdata_in;
  logic [11:0]           csr_raddr_in;
  logic [DATA_WIDTH-1:0] csr_rdata_out;
  logic                  interrupt_en_out;
  logic [ADDR_WIDTH-1:0] isr_pc_out;
  logic                  busy_out;

  modport master (
    output irq_ext_in, irq_sw_in, irq_timer_in, ecall_in, mret_in, stall_in,
           exe_jump_enable_in, epc_in, csr_we_in, csr_waddr_in, csr_wdata_in, csr_raddr_in,
    input  csr_rdata_out, interrupt_en_out, isr_pc_out, busy_out
  );

  modport slave (
    input  irq_ext_in, irq_sw_in, irq_timer_in, ecall_in, mret_in, stall_in,
           exe_jump_enable_in, epc_in, csr_we_in, csr_waddr_in, csr_wdata_in, csr_raddr_in,
    output csr_rdata_out, interrupt_en_out, isr_pc_out, busy_out
  );
endinterface

// File: rtl/trap_csr_file.sv
// Machine trap CSRs with combinational read and a software write port; the
// hardware trap/mret update shares the edge and overrides software on the fields it touches.
module trap_csr_file
  import trap_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_MTVEC = 32'h0000_0100
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  irq_ext,
  input  logic                  irq_sw,
  input  logic                  irq_timer,
  input  logic                  csr_we,
  input  logic [11:0]           csr_waddr,
  input  logic [DATA_WIDTH-1:0] csr_wdata,
  input  logic [11:0]           csr_raddr,
  output logic [DATA_WIDTH-1:0] csr_rdata,
  input  logic                  hw_trap,
  input  logic                  hw_mret,
  input  logic [ADDR_WIDTH-1:0] hw_epc,
  input  cause_t                hw_cause,
  output logic [2:0]            pending,
  output logic [DATA_WIDTH-1:0] mtvec,
  output logic [DATA_WIDTH-1:0] mepc
);
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

  logic                  mstatus_mie, mstatus_mpie;
  logic                  mie_ext, mie_sw, mie_tmr;
  logic                  mip_ext, mip_sw, mip_tmr;
  logic [DATA_WIDTH-1:0] mcause;

  // {ext, sw, timer}, already gated by mie and the global enable
  assign pending = {mip_ext & mie_ext, mip_sw & mie_sw, mip_tmr & mie_tmr} & {3{mstatus_mie}};

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      {mie_ext, mie_sw, mie_tmr} <= 3'b000;
      {mip_ext, mip_sw, mip_tmr} <= 3'b000;
      mtvec        <= RESET_MTVEC;
      mepc         <= DATA_WIDTH'(ZERO);
      mcause       <= DATA_WIDTH'(ZERO);
    end else begin
      {mip_ext, mip_sw, mip_tmr} <= {irq_ext, irq_sw, irq_timer};
      if (csr_we) begin
        case (csr_waddr)
          CSR_MSTATUS: begin
            mstatus_mie  <= csr_wdata[MSTATUS_MIE_BIT];
            mstatus_mpie <= csr_wdata[MSTATUS_MPIE_BIT];
          end
          CSR_MIE:    {mie_ext, mie_sw, mie_tmr} <= {csr_wdata[11], csr_wdata[3], csr_wdata[7]};
          CSR_MTVEC:  mtvec  <= csr_wdata;
          CSR_MEPC:   mepc   <= csr_wdata & ALIGN_MASK;
          CSR_MCAUSE: mcause <= csr_wdata;
          default: ;
        endcase
      end
      // Later assignments win, so hardware updates take precedence over the software write
      if (hw_trap) begin
        mepc         <= DATA_WIDTH'(hw_epc) & ALIGN_MASK;
        mcause       <= DATA_WIDTH'(cause_word(hw_cause));
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end
      if (hw_mret) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end
    end
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_raddr)
      CSR_MSTATUS: begin
        csr_rdata[MSTATUS_MIE_BIT]  = mstatus_mie;
        csr_rdata[MSTATUS_MPIE_BIT] = mstatus_mpie;
      end
      CSR_MIE: begin
        csr_rdata[11] = mie_ext;
        csr_rdata[3]  = mie_sw;
        csr_rdata[7]  = mie_tmr;
      end
      CSR_MIP: begin
        csr_rdata[11] = mip_ext;
        csr_rdata[3]  = mip_sw;
        csr_rdata[7]  = mip_tmr;
      end
      CSR_MTVEC:  csr_rdata = mtvec;
      CSR_MEPC:   csr_rdata = mepc;
      CSR_MCAUSE: csr_rdata = mcause;
      default: ;
    endcase
  end
endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: picks the winning cause, waits for a safe pipeline point,
// then issues a one-cycle redirect (interrupt: 3 cycles line-to-redirect, ecall 2, mret 1).
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_MTVEC = 32'h0000_0100
) (
  input logic        clk_in,
  input logic        reset_in,
  trap_ctrl_if.slave bus
);
  state_t                state;
  cause_t                cause_q, win;
  logic                  int_en_q;
  logic [ADDR_WIDTH-1:0] isr_pc_q;
  logic [DATA_WIDTH-1:0] mtvec, mepc, vec_base, vector;
  logic [2:0]            pending;
  logic                  trap_req, pipe_safe;

  trap_csr_file #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .RESET_MTVEC(RESET_MTVEC)
  ) u_csr (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .irq_ext  (bus.irq_ext_in),
    .irq_sw   (bus.irq_sw_in),
    .irq_timer(bus.irq_timer_in),
    .csr_we   (bus.csr_we_in),
    .csr_waddr(bus.csr_waddr_in),
    .csr_wdata(bus.csr_wdata_in),
    .csr_raddr(bus.csr_raddr_in),
    .csr_rdata(bus.csr_rdata_out),
    .hw_trap  (state == ST_TRAP),
    .hw_mret  (state == ST_MRET),
    .hw_epc   (bus.epc_in),
    .hw_cause (cause_q),
    .pending  (pending),
    .mtvec    (mtvec),
    .mepc     (mepc)
  );

  assign trap_req  = bus.ecall_in || (pending != 3'b000);
  assign pipe_safe = (bus.stall_in == 6'b000000) && (bus.exe_jump_enable_in != STOP);

  always_comb begin
    win = '{irq: 1'b0, code: CAUSE_ECALL_M};
    if (!bus.ecall_in) begin
      if (pending[2])      win = '{irq: 1'b1, code: CAUSE_MEI};
      else if (pending[1]) win = '{irq: 1'b1, code: CAUSE_MSI};
      else                 win = '{irq: 1'b1, code: CAUSE_MTI};
    end
  end

  // Vectored mode offsets interrupts only; ecall always lands on the base
  always_comb begin
    vec_base = {mtvec[DATA_WIDTH-1:2], 2'b00};
    vector   = vec_base;
    if (mtvec[1:0] == 2'b01 && cause_q.irq)
      vector = vec_base + DATA_WIDTH'({cause_q.code, 2'b00});
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state    <= ST_IDLE;
      cause_q  <= '0;
      int_en_q <= 1'b0;
      isr_pc_q <= '0;
    end else begin
      int_en_q <= 1'b0;
      isr_pc_q <= '0;
      case (state)
        ST_IDLE: begin
          if (trap_req) begin
            state   <= ST_WAIT;
            cause_q <= win;
          end else if (bus.mret_in) begin
            state    <= ST_MRET;
            int_en_q <= 1'b1;
            isr_pc_q <= ADDR_WIDTH'(mepc);
          end
        end
        ST_WAIT: begin
          if (pipe_safe) begin
            state    <= ST_TRAP;
            int_en_q <= 1'b1;
            isr_pc_q <= ADDR_WIDTH'(vector);
          end
        end
        ST_TRAP, ST_MRET: state <= ST_HOLD;
        default:          state <= ST_IDLE;
      endcase
    end
  end

  assign bus.interrupt_en_out = int_en_q;
  assign bus.isr_pc_out       = isr_pc_q;
  assign bus.busy_out         = (state != ST_IDLE);
endmodule
